// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end for the sequence detector.
// Words arrive over valid/ready; one bit per clk leaves on a registered x.
module seq_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic             r_x;
    logic             w_x_nxt;
    logic             r_x_valid;
    logic             w_x_valid_nxt;
    logic             r_busy;

    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_load_bit;
    logic [WIDTH-1:0] w_load_rem;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_next_rem;

    // The first bit goes straight into r_x at load time, so the
    // shift register only ever holds the bits still to be sent.
    assign w_load_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign w_load_rem = MSB_FIRST ? (din << 1) : (din >> 1);
    assign w_next_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_next_rem = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);

    // Ready in IDLE and on the last bit of a word, so streams have no gap.
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);
    assign w_ready  = !rst && ((r_state == S_IDLE) || w_last);
    assign w_accept = din_valid && w_ready;

    assign din_ready = w_ready;
    assign x         = r_x;
    assign x_valid   = r_x_valid;
    assign busy      = r_busy;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shreg_nxt   = r_shreg;
        w_x_nxt       = r_x;
        w_x_valid_nxt = r_x_valid;
        unique case (r_state)
            S_IDLE: begin
                w_x_nxt       = IDLE_BIT;
                w_x_valid_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt   = S_SHIFT;
                    w_cnt_nxt     = '0;
                    w_shreg_nxt   = w_load_rem;
                    w_x_nxt       = w_load_bit;
                    w_x_valid_nxt = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_accept) begin
                    w_cnt_nxt     = '0;
                    w_shreg_nxt   = w_load_rem;
                    w_x_nxt       = w_load_bit;
                    w_x_valid_nxt = 1'b1;
                end else if (w_last) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_x_nxt       = IDLE_BIT;
                    w_x_valid_nxt = 1'b0;
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                    w_shreg_nxt   = w_next_rem;
                    w_x_nxt       = w_next_bit;
                    w_x_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_x_nxt       = IDLE_BIT;
                w_x_valid_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_x       <= IDLE_BIT;
            r_x_valid <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_x       <= w_x_nxt;
            r_x_valid <= w_x_valid_nxt;
        end
    end

    // busy is its own flop that tracks x_valid exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= w_x_valid_nxt;
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: directed and random checks of seq_serializer,
// both bit orders, against a queue-of-bits reference model.
module tb_seq_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;

    logic rdy_m, x_m, xv_m, busy_m;
    logic rdy_l, x_l, xv_l, busy_l;

    int checks = 0;
    int failures = 0;

    bit q_m[$];
    bit q_l[$];
    bit hist[$];
    bit rec = 1'b0;

    always #5 clk = ~clk;

    seq_serializer #(
        .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
    ) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .x(x_m), .x_valid(xv_m), .busy(busy_m)
    );

    seq_serializer #(
        .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)
    ) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .x(x_l), .x_valid(xv_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string sfx);
        int ex_m, ev_m, ex_l, ev_l;
        ev_m = (q_m.size() > 0) ? 1 : 0;
        ex_m = (q_m.size() > 0) ? int'(q_m[0]) : 0;
        ev_l = (q_l.size() > 0) ? 1 : 0;
        ex_l = (q_l.size() > 0) ? int'(q_l[0]) : 0;
        chk({"x_m", sfx}, int'(x_m), ex_m);
        chk({"xv_m", sfx}, int'(xv_m), ev_m);
        chk({"busy_m", sfx}, int'(busy_m), ev_m);
        chk({"x_l", sfx}, int'(x_l), ex_l);
        chk({"xv_l", sfx}, int'(xv_l), ev_l);
        chk({"busy_l", sfx}, int'(busy_l), ev_l);
    endtask

    // One clock: drive inputs, check ready, take the edge, check outputs.
    task automatic step(input logic v, input logic [7:0] d);
        int rdy;
        din = d;
        din_valid = v;
        #1;
        rdy = (!rst && q_m.size() <= 1) ? 1 : 0;
        chk("ready_m", int'(rdy_m), rdy);
        chk("ready_l", int'(rdy_l), rdy);
        @(posedge clk);
        if (q_m.size() > 0) void'(q_m.pop_front());
        if (q_l.size() > 0) void'(q_l.pop_front());
        if (v && rdy == 1) begin
            for (int k = 0; k < 8; k++) begin
                q_m.push_back(d[7-k]);
                q_l.push_back(d[k]);
            end
        end
        if (rst) begin
            q_m.delete();
            q_l.delete();
        end
        #1;
        chk_out("");
        if (rec && xv_m) hist.push_back(x_m);
    endtask

    // Raise reset between edges and check the outputs drop at once.
    task automatic async_rst();
        #2;
        rst = 1'b1;
        #1;
        q_m.delete();
        q_l.delete();
        chk_out("_arst");
        chk("ready_m_arst", int'(rdy_m), 0);
        chk("ready_l_arst", int'(rdy_l), 0);
    endtask

    initial begin
        logic [7:0] ymask;
        int ones;

        // Reset with clock running, valid asserted: nothing transfers.
        step(1'b0, 8'h00);
        step(1'b1, 8'h3C);
        step(1'b1, 8'h3C);
        rst = 1'b0;

        // Single word, MSB first and LSB first.
        step(1'b1, 8'hA5);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00);

        // Back-to-back words with valid held.
        ones = 0;
        step(1'b1, 8'hA5);
        for (int i = 0; i < 7; i++) step(1'b1, 8'h5A);
        for (int i = 0; i < 10; i++) begin
            if (rdy_m) ones++;
            step(1'b0, 8'h00);
        end
        chk("b2b_idle_ready", ones, 10);

        // LSB word 8'h01 with valid held through the shift.
        step(1'b1, 8'h01);
        for (int i = 0; i < 7; i++) step(1'b1, 8'hEE);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00);

        // Reset during bit 3 of 8'hFF, then resume.
        step(1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        async_rst();
        step(1'b1, 8'h77);
        rst = 1'b0;
        step(1'b1, 8'hC3);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00);

        // Detector chain: overlapping 101 in 8'b1010_1000.
        hist.delete();
        rec = 1'b1;
        step(1'b1, 8'b1010_1000);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00);
        rec = 1'b0;
        chk("det_len", hist.size(), 8);
        ymask = '0;
        for (int k = 2; k < hist.size() && k < 8; k++) begin
            if (hist[k-2] && !hist[k-1] && hist[k]) ymask[k] = 1'b1;
        end
        chk("det_y", int'(ymask), 8'b0001_0100);

        // Random traffic with one mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                async_rst();
                step(1'b1, 8'($urandom));
                rst = 1'b0;
            end
            step($urandom_range(0, 3) != 0, 8'($urandom));
        end
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
